// File: rtl/svm_result_gen.sv
// SVM result generator: accumulates per-block partial dot products into a window score,
// adds the bias with saturation, and emits one classification strobe per slide window.
module svm_result_gen #(
    parameter int SW_W       = 11,
    parameter int NUM_SW     = 1200,
    parameter int BLK_PER_SW = 105,
    parameter int PS_W       = 24,
    parameter int ACC_W      = 32,
    parameter logic signed [ACC_W-1:0] BIAS = {ACC_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              i_valid,
    output logic              i_ready,
    input  logic [PS_W-1:0]   i_psum,
    output logic              o_valid,
    output logic              is_person,
    output logic [SW_W-1:0]   sw_id,
    output logic [ACC_W-1:0]  score
);

    localparam int BLK_CW = (BLK_PER_SW > 1) ? $clog2(BLK_PER_SW) : 1;
    localparam logic [BLK_CW-1:0] BLK_LAST = BLK_CW'(BLK_PER_SW - 1);
    localparam logic [SW_W-1:0]   SW_LAST  = SW_W'(NUM_SW - 1);
    localparam logic [ACC_W-1:0]  ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0]  ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [0:0] {
        ST_ACC = 1'b0,
        ST_OUT = 1'b1
    } state_t;

    // Two's-complement add clamped to the accumulator range instead of wrapping.
    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                                  input logic [ACC_W-1:0] b);
        logic [ACC_W:0] s;
        s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        if (s[ACC_W] != s[ACC_W-1]) begin
            sat_add = s[ACC_W] ? ACC_MIN : ACC_MAX;
        end else begin
            sat_add = s[ACC_W-1:0];
        end
    endfunction

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ACC_W-1:0]  r_acc;
    logic [BLK_CW-1:0] r_blk_cnt;
    logic [ACC_W-1:0]  r_score_pend;
    logic [SW_W-1:0]   r_next_id;
    logic [ACC_W-1:0]  w_psum_ext;
    logic [ACC_W-1:0]  w_acc_sum;
    logic [ACC_W-1:0]  w_final;
    logic              w_accept;
    logic              w_last;

    assign i_ready    = (r_state == ST_ACC);
    assign w_accept   = i_valid && i_ready && !frame_start;
    assign w_last     = w_accept && (r_blk_cnt == BLK_LAST);
    assign w_psum_ext = {{(ACC_W-PS_W){i_psum[PS_W-1]}}, i_psum};
    assign w_acc_sum  = sat_add(r_acc, w_psum_ext);
    assign w_final    = sat_add(w_acc_sum, BIAS);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_ACC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; frame_start always forces accumulation mode.
    always_comb begin
        w_state_nxt = r_state;
        if (frame_start) begin
            w_state_nxt = ST_ACC;
        end else begin
            case (r_state)
                ST_ACC:  w_state_nxt = w_last ? ST_OUT : ST_ACC;
                ST_OUT:  w_state_nxt = ST_ACC;
                default: w_state_nxt = ST_ACC;
            endcase
        end
    end

    // Accumulation datapath and registered result outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_acc        <= {ACC_W{1'b0}};
            r_blk_cnt    <= {BLK_CW{1'b0}};
            r_score_pend <= {ACC_W{1'b0}};
            r_next_id    <= {SW_W{1'b0}};
            o_valid      <= 1'b0;
            is_person    <= 1'b0;
            sw_id        <= {SW_W{1'b0}};
            score        <= {ACC_W{1'b0}};
        end else if (frame_start) begin
            r_acc     <= {ACC_W{1'b0}};
            r_blk_cnt <= {BLK_CW{1'b0}};
            r_next_id <= {SW_W{1'b0}};
            o_valid   <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            if (w_accept) begin
                r_acc <= w_acc_sum;
                if (w_last) begin
                    r_blk_cnt    <= {BLK_CW{1'b0}};
                    r_score_pend <= w_final;
                end else begin
                    r_blk_cnt <= r_blk_cnt + BLK_CW'(1'b1);
                end
            end else begin
                r_acc <= r_acc;
            end
            // The pending score becomes visible together with its strobe and window id.
            if (r_state == ST_OUT) begin
                o_valid   <= 1'b1;
                score     <= r_score_pend;
                is_person <= !r_score_pend[ACC_W-1] && (r_score_pend != {ACC_W{1'b0}});
                sw_id     <= r_next_id;
                r_next_id <= (r_next_id == SW_LAST) ? {SW_W{1'b0}} : r_next_id + SW_W'(1'b1);
                r_acc     <= {ACC_W{1'b0}};
            end else begin
                r_next_id <= r_next_id;
            end
        end
    end

endmodule

// File: tb/tb_svm_result_gen.sv
// Directed bench for svm_result_gen: two instances cover the bias/window-id path and
// the narrow-accumulator saturation/frame_start path.
module tb_svm_result_gen;

    logic        clk = 1'b0;
    logic        rst;
    int          vectors = 0;
    int          miscompares = 0;

    // Instance A: BLK_PER_SW=4, BIAS=-10, NUM_SW=3, ACC_W=32
    logic        a_fs, a_valid, a_ready, a_o_valid, a_is_person;
    logic [23:0] a_psum;
    logic [10:0] a_sw_id;
    logic [31:0] a_score;
    int          a_pulses;
    logic [10:0] a_cap_id;
    logic [31:0] a_cap_score;
    logic        a_cap_person;

    // Instance B: BLK_PER_SW=4, BIAS=0, ACC_W=PS_W+1=25
    logic        b_fs, b_valid, b_ready, b_o_valid, b_is_person;
    logic [23:0] b_psum;
    logic [10:0] b_sw_id;
    logic [24:0] b_score;
    int          b_pulses;
    logic [10:0] b_cap_id;
    logic [24:0] b_cap_score;
    logic        b_cap_person;

    svm_result_gen #(.SW_W(11), .NUM_SW(3), .BLK_PER_SW(4), .PS_W(24), .ACC_W(32),
                     .BIAS(-32'sd10)) dut_a (
        .clk(clk), .rst(rst), .frame_start(a_fs), .i_valid(a_valid), .i_ready(a_ready),
        .i_psum(a_psum), .o_valid(a_o_valid), .is_person(a_is_person), .sw_id(a_sw_id),
        .score(a_score));

    svm_result_gen #(.SW_W(11), .NUM_SW(1200), .BLK_PER_SW(4), .PS_W(24), .ACC_W(25),
                     .BIAS(25'sd0)) dut_b (
        .clk(clk), .rst(rst), .frame_start(b_fs), .i_valid(b_valid), .i_ready(b_ready),
        .i_psum(b_psum), .o_valid(b_o_valid), .is_person(b_is_person), .sw_id(b_sw_id),
        .score(b_score));

    always #5 clk = ~clk;

    task automatic beat_a(input logic [23:0] v);
        @(negedge clk);
        a_fs = 1'b0; a_valid = 1'b1; a_psum = v;
    endtask

    task automatic idle_a(input int n);
        repeat (n) begin
            @(negedge clk);
            a_fs = 1'b0; a_valid = 1'b0;
            if (a_o_valid) begin
                a_pulses++;
                a_cap_id = a_sw_id; a_cap_score = a_score; a_cap_person = a_is_person;
            end
        end
    endtask

    task automatic beat_b(input logic [23:0] v);
        @(negedge clk);
        b_fs = 1'b0; b_valid = 1'b1; b_psum = v;
    endtask

    task automatic idle_b(input int n);
        repeat (n) begin
            @(negedge clk);
            b_fs = 1'b0; b_valid = 1'b0;
            if (b_o_valid) begin
                b_pulses++;
                b_cap_id = b_sw_id; b_cap_score = b_score; b_cap_person = b_is_person;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({a_o_valid, a_is_person, a_sw_id, a_score} !== 45'd0) begin
            miscompares++; $display("FAIL reset_a_outputs: got %h expected 0", {a_o_valid, a_is_person, a_sw_id, a_score});
        end
        vectors++;
        if ({b_o_valid, b_is_person, b_sw_id, b_score} !== 38'd0) begin
            miscompares++; $display("FAIL reset_b_outputs: got %h expected 0", {b_o_valid, b_is_person, b_sw_id, b_score});
        end
        vectors++;
        if ({a_ready, b_ready} !== 2'b11) begin
            miscompares++; $display("FAIL reset_ready: got %b expected 11", {a_ready, b_ready});
        end
        rst = 1'b1;
    endtask

    task automatic test_basic;
        beat_a(24'd5); beat_a(24'd5); beat_a(24'd5); beat_a(24'd5);
        @(negedge clk); a_valid = 1'b0;
        vectors++;
        if ({a_o_valid, a_ready} !== 2'b00) begin
            miscompares++; $display("FAIL basic_out_state: got o_valid/i_ready %b expected 00", {a_o_valid, a_ready});
        end
        @(negedge clk);
        vectors++;
        if (a_o_valid !== 1'b1) begin
            miscompares++; $display("FAIL basic_latency: got o_valid %b expected 1", a_o_valid);
        end
        vectors++;
        if (a_score !== 32'd10 || a_is_person !== 1'b1 || a_sw_id !== 11'd0) begin
            miscompares++; $display("FAIL basic_result: got score %0d person %b id %0d expected 10 1 0", $signed(a_score), a_is_person, a_sw_id);
        end
        @(negedge clk);
        vectors++;
        if (a_o_valid !== 1'b0 || a_score !== 32'd10 || a_ready !== 1'b1) begin
            miscompares++; $display("FAIL basic_hold: got o_valid %b score %0d ready %b expected 0 10 1", a_o_valid, $signed(a_score), a_ready);
        end
    endtask

    task automatic test_zero_score;
        a_pulses = 0;
        beat_a(24'd2); beat_a(24'd2); beat_a(24'd3); beat_a(24'd3);
        idle_a(6);
        vectors++;
        if (a_pulses !== 1) begin
            miscompares++; $display("FAIL zero_pulses: got %0d expected 1", a_pulses);
        end
        vectors++;
        if (a_cap_score !== 32'd0 || a_cap_person !== 1'b0 || a_cap_id !== 11'd1) begin
            miscompares++; $display("FAIL zero_result: got score %0d person %b id %0d expected 0 0 1", $signed(a_cap_score), a_cap_person, a_cap_id);
        end
    endtask

    task automatic test_wrap;
        logic [10:0] exp_id [4];
        exp_id[0] = 11'd0; exp_id[1] = 11'd1; exp_id[2] = 11'd2; exp_id[3] = 11'd0;
        @(negedge clk); a_fs = 1'b1;
        idle_a(2);
        for (int w = 0; w < 4; w++) begin
            a_pulses = 0;
            beat_a(24'd1); beat_a(24'd1); beat_a(24'd1); beat_a(24'd1);
            idle_a(5);
            vectors++;
            if (a_pulses !== 1 || a_cap_id !== exp_id[w] || a_cap_score !== -32'sd6) begin
                miscompares++; $display("FAIL wrap_win%0d: got pulses %0d id %0d score %0d expected 1 %0d -6", w, a_pulses, a_cap_id, $signed(a_cap_score), exp_id[w]);
            end
            vectors++;
            if (a_sw_id !== exp_id[w] || a_o_valid !== 1'b0) begin
                miscompares++; $display("FAIL wrap_hold%0d: got id %0d o_valid %b expected %0d 0", w, a_sw_id, a_o_valid, exp_id[w]);
            end
        end
    endtask

    task automatic test_saturation;
        b_pulses = 0;
        beat_b(24'h7FFFFF); beat_b(24'h7FFFFF); beat_b(24'h7FFFFF); beat_b(24'h7FFFFF);
        idle_b(6);
        vectors++;
        if (b_pulses !== 1 || b_cap_score !== 25'h0FFFFFF || b_cap_person !== 1'b1 || b_cap_id !== 11'd0) begin
            miscompares++; $display("FAIL sat_pos: got pulses %0d score %h person %b id %0d expected 1 0ffffff 1 0", b_pulses, b_cap_score, b_cap_person, b_cap_id);
        end
        b_pulses = 0;
        beat_b(24'h800000); beat_b(24'h800000); beat_b(24'h800000); beat_b(24'h800000);
        idle_b(6);
        vectors++;
        if (b_pulses !== 1 || b_cap_score !== 25'h1000000 || b_cap_person !== 1'b0 || b_cap_id !== 11'd1) begin
            miscompares++; $display("FAIL sat_neg: got pulses %0d score %h person %b id %0d expected 1 1000000 0 1", b_pulses, b_cap_score, b_cap_person, b_cap_id);
        end
    endtask

    task automatic test_frame_start;
        b_pulses = 0;
        beat_b(24'd1); beat_b(24'd1);
        @(negedge clk); b_fs = 1'b1; b_valid = 1'b1; b_psum = 24'd100;
        beat_b(24'd1); beat_b(24'd1); beat_b(24'd1); beat_b(24'd1);
        idle_b(6);
        vectors++;
        if (b_pulses !== 1) begin
            miscompares++; $display("FAIL fs_pulses: got %0d expected 1", b_pulses);
        end
        vectors++;
        if (b_cap_score !== 25'd4 || b_cap_id !== 11'd0 || b_cap_person !== 1'b1) begin
            miscompares++; $display("FAIL fs_result: got score %0d id %0d person %b expected 4 0 1", $signed(b_cap_score), b_cap_id, b_cap_person);
        end
    endtask

    task automatic test_reset_in_out;
        for (int i = 0; i < 4; i++) begin
            idle_a(int'($urandom_range(0, 2)));
            beat_a(24'd5);
        end
        @(negedge clk); a_valid = 1'b0; rst = 1'b0;
        vectors++;
        if (a_ready !== 1'b0) begin
            miscompares++; $display("FAIL rst_out_reached: got i_ready %b expected 0", a_ready);
        end
        @(negedge clk);
        vectors++;
        if ({a_o_valid, a_is_person, a_sw_id, a_score} !== 45'd0 || a_ready !== 1'b1) begin
            miscompares++; $display("FAIL rst_out_clear: got %h ready %b expected 0 1", {a_o_valid, a_is_person, a_sw_id, a_score}, a_ready);
        end
        rst = 1'b1;
        a_pulses = 0;
        idle_a(5);
        vectors++;
        if (a_pulses !== 0) begin
            miscompares++; $display("FAIL rst_out_no_strobe: got %0d pulses expected 0", a_pulses);
        end
        for (int i = 0; i < 4; i++) begin
            idle_a(int'($urandom_range(0, 3)));
            beat_a(24'd5);
        end
        idle_a(6);
        vectors++;
        if (a_pulses !== 1 || a_cap_id !== 11'd0 || a_cap_score !== 32'd10) begin
            miscompares++; $display("FAIL rst_out_next: got pulses %0d id %0d score %0d expected 1 0 10", a_pulses, a_cap_id, $signed(a_cap_score));
        end
    endtask

    initial begin
        rst = 1'b0;
        a_fs = 1'b0; a_valid = 1'b0; a_psum = 24'd0;
        b_fs = 1'b0; b_valid = 1'b0; b_psum = 24'd0;
        a_pulses = 0; a_cap_id = 11'd0; a_cap_score = 32'd0; a_cap_person = 1'b0;
        b_pulses = 0; b_cap_id = 11'd0; b_cap_score = 25'd0; b_cap_person = 1'b0;
        test_reset;
        test_basic;
        test_zero_score;
        test_wrap;
        test_saturation;
        test_frame_start;
        test_reset_in_out;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/svm_result_gen.md
SVM_RESULT_GEN -- requirements
Module: svm_result_gen

Interface
REQ-001 SHALL have parameter SW_W, default 11: slide-window index width.
REQ-002 SHALL have parameter NUM_SW, default 1200: slide windows per frame, range 1..2^SW_W.
REQ-003 SHALL have parameter BLK_PER_SW, default 105: partial sums per window, range >= 1.
REQ-004 SHALL have parameter PS_W, default 24: signed partial-sum width.
REQ-005 SHALL have parameter ACC_W, default 32: signed accumulator width, ACC_W > PS_W.
REQ-006 SHALL have parameter BIAS, default 0: signed ACC_W-bit SVM bias.
REQ-007 SHALL have port clk  input  1: clock; all logic rising-edge.
REQ-008 SHALL have port rst  input  1: reset, synchronous, active-low.
REQ-009 SHALL have port frame_start  input  1: one-cycle pulse; restarts window numbering.
REQ-010 SHALL have port i_valid  input  1: partial-sum beat valid.
REQ-011 SHALL have port i_ready  output  1: block accepts a beat when i_valid && i_ready.
REQ-012 SHALL have port i_psum  input  PS_W: signed partial dot product, one HOG block.
REQ-013 SHALL have port o_valid  output  1: one-cycle result strobe.
REQ-014 SHALL have port is_person  output  1: classification of the window in sw_id.
REQ-015 SHALL have port sw_id  output  SW_W: index of the most recent result window.
REQ-016 SHALL have port score  output  ACC_W: signed final score, acc + BIAS, saturated.

Function
REQ-017 SHALL implement states ACC and OUT; reset state ACC.
REQ-018 In ACC, i_ready SHALL be 1; each accepted beat adds sign-extended i_psum to acc and increments blk_cnt.
REQ-019 The accept where blk_cnt == BLK_PER_SW-1 SHALL clear blk_cnt, latch score = sat(acc + i_psum + BIAS), and go to OUT.
REQ-020 In OUT, i_ready SHALL be 0; next cycle SHALL drive o_valid=1 and is_person = (score > 0, strict), clear acc, and return to ACC.
REQ-021 Latency from the last accepted beat to o_valid SHALL be 2 cycles; throughput SHALL be one window per BLK_PER_SW+1 cycles minimum.
REQ-022 All additions SHALL saturate to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; no wrap.
REQ-023 score == 0 SHALL give is_person=0.
REQ-024 sw_id SHALL update together with o_valid: first result after reset or frame_start → 0, then previous+1; after NUM_SW-1 it SHALL wrap to 0.
REQ-025 sw_id, is_person, score SHALL hold their values between o_valid strobes; o_valid SHALL be 0 otherwise.
REQ-026 frame_start SHALL clear acc and blk_cnt, discard any partial window, cancel a pending OUT strobe, force state ACC, and make the next result carry sw_id=0.
REQ-027 frame_start coincident with an accepted beat SHALL take priority; the beat SHALL be dropped.
REQ-028 i_valid low SHALL stall accumulation with no state change; gaps of any length SHALL be tolerated.

Reset
REQ-029 On rst low at a clock edge: o_valid=0, is_person=0, sw_id=0, score=0, acc=0, blk_cnt=0, state ACC, i_ready=1.
REQ-030 Reset asserted mid-window or in OUT SHALL discard the partial result and emit no strobe.
REQ-031 The first window after reset SHALL report sw_id=0 without needing frame_start.

Verification
REQ-032 BLK_PER_SW=4, BIAS=-10, psums 5,5,5,5 back-to-back → o_valid 2 cycles after the 4th beat, score=10, is_person=1, sw_id=0.
REQ-033 psums 2,2,3,3, BIAS=-10 → score=0, is_person=0; the next window reports sw_id=1.
REQ-034 NUM_SW=3, run 4 windows → sw_id sequence 0,1,2,0, one o_valid pulse each, held between strobes.
REQ-035 ACC_W=PS_W+1, all psums at max positive → score saturates at 2^(ACC_W-1)-1, no sign flip.
REQ-036 frame_start after 2 of 4 beats, then 4 new beats of 1, BIAS=0 → single result score=4, sw_id=0.
REQ-037 Random i_valid gaps plus rst low in OUT → no o_valid, all outputs zero, next window sw_id=0.
